// File: rtl/dmem_pkg.sv
// Shared definitions for the dual-core data-memory arbiter: op codes, FSM
// states, RAM geometry and the byte-to-word address helper.
package dmem_pkg;

  localparam int DMEM_DATA_W  = 32;
  localparam int DMEM_AW      = 9;
  localparam int DMEM_BYTE_AW = 32;
  localparam int DMEM_DEPTH   = 512;

  localparam logic [1:0] OP_LD   = 2'b00;
  localparam logic [1:0] OP_ST   = 2'b01;
  localparam logic [1:0] OP_XCHG = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    WR,
    DONE
  } state_e;

  // The two low byte-address bits only flag misalignment; they never select a word.
  function automatic logic [DMEM_AW-1:0] word_idx(input logic [DMEM_BYTE_AW-1:0] addr);
    return addr[DMEM_AW+1:2];
  endfunction

endpackage

// File: rtl/dmem_xchg_arbiter_if.sv
// Bundle of the two core request ports, the loader handshake and the RAM port.
// The arbiter uses the slave view; the cores/RAM environment uses master.
interface dmem_xchg_arbiter_if #(
  parameter int DATA_W  = 32,
  parameter int AW      = 9,
  parameter int BYTE_AW = 32
);

  logic               ld_busy;

  logic               c0_req;
  logic [1:0]         c0_op;
  logic [BYTE_AW-1:0] c0_addr;
  logic [DATA_W-1:0]  c0_wdata;
  logic               c0_ack;
  logic [DATA_W-1:0]  c0_rdata;
  logic               c0_misalign;

  logic               c1_req;
  logic [1:0]         c1_op;
  logic [BYTE_AW-1:0] c1_addr;
  logic [DATA_W-1:0]  c1_wdata;
  logic               c1_ack;
  logic [DATA_W-1:0]  c1_rdata;
  logic               c1_misalign;

  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;

  modport slave (
    input  ld_busy,
    input  c0_req, c0_op, c0_addr, c0_wdata,
    output c0_ack, c0_rdata, c0_misalign,
    input  c1_req, c1_op, c1_addr, c1_wdata,
    output c1_ack, c1_rdata, c1_misalign,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output ld_busy,
    output c0_req, c0_op, c0_addr, c0_wdata,
    input  c0_ack, c0_rdata, c0_misalign,
    output c1_req, c1_op, c1_addr, c1_wdata,
    input  c1_ack, c1_rdata, c1_misalign,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. A lone requester always wins; on a tie the core
// that was not granted last wins. last_grant only moves on an accept strobe.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant
);

  logic last_grant;

  // NOTE: grant gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    grant = 1'b0;
    unique case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  // Reset to core 1 so that core 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/dmem_xchg_arbiter.sv
// Serialises lw / sw / exchng from two cores onto one single-port RAM. Only one
// transaction is in flight, so an exchange's read and write cannot be split.
module dmem_xchg_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int AW      = DMEM_AW,
  parameter int BYTE_AW = DMEM_BYTE_AW
) (
  input logic                clk,
  input logic                rst,
  dmem_xchg_arbiter_if.slave bus
);

  state_e             state, state_nx;
  logic [1:0]         req;
  logic               grant, accept, done_nx;
  logic [1:0]         op_in, op_q;
  logic [BYTE_AW-1:0] addr_in;
  logic [DATA_W-1:0]  wdata_in, wdata_q;
  logic [AW-1:0]      addr_q;
  logic               sel, mis_q;
  logic [DATA_W-1:0]  rdata0, rdata1;
  logic               ack0, ack1, mis0, mis1;

  assign req    = {bus.c1_req, bus.c0_req};
  assign accept = (state == IDLE) && !bus.ld_busy && (req != 2'b00);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  assign op_in    = grant ? bus.c1_op    : bus.c0_op;
  assign addr_in  = grant ? bus.c1_addr  : bus.c0_addr;
  assign wdata_in = grant ? bus.c1_wdata : bus.c0_wdata;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = (op_in == OP_ST) ? WR : RD;
      RD:      state_nx = LAT;
      LAT, WR: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign done_nx = (state == LAT) || (state == WR);

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sel     <= 1'b0;
      op_q    <= OP_LD;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      mis0    <= 1'b0;
      mis1    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sel     <= grant;
        op_q    <= (op_in == OP_ST || op_in == OP_XCHG) ? op_in : OP_LD;
        addr_q  <= word_idx(addr_in);
        wdata_q <= wdata_in;
        mis_q   <= (addr_in[1:0] != 2'b00);
      end
      // Read data arrives in LAT; stores never touch the rdata registers.
      if (state == LAT) begin
        if (sel) rdata1 <= bus.mem_rdata;
        else     rdata0 <= bus.mem_rdata;
      end
      ack0 <= done_nx && !sel;
      ack1 <= done_nx && sel;
      mis0 <= done_nx && !sel && mis_q;
      mis1 <= done_nx && sel && mis_q;
    end
  end

  // RAM port is decoded from state, so an async reset drops mem_we at once
  // and the port is quiet whenever the loader may own the RAM.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state)
      RD: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = addr_q;
      end
      LAT: if (op_q == OP_XCHG) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
      end
      WR: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  assign bus.c0_ack      = ack0;
  assign bus.c1_ack      = ack1;
  assign bus.c0_misalign = mis0;
  assign bus.c1_misalign = mis1;
  assign bus.c0_rdata    = rdata0;
  assign bus.c1_rdata    = rdata1;

endmodule

// File: tb/tb_dmem_xchg_arbiter.sv
// Directed bench for dmem_xchg_arbiter with a behavioural 512x32 synchronous RAM.
// Latencies are counted in falling edges from the edge the request is driven on.
module tb_dmem_xchg_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_xchg_arbiter_if bus ();

  dmem_xchg_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram [DMEM_DEPTH] = '{default: 32'h0};

  // Read-first single-port RAM: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  int          checks   = 0;
  int          failures = 0;
  int          stray    = 0;
  int          lat [2];
  logic [31:0] rd  [2];
  logic        mis [2];
  logic        seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int core, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wd);
    if (core == 0) begin
      bus.c0_op = op; bus.c0_addr = addr; bus.c0_wdata = wd; bus.c0_req = 1'b1;
    end else begin
      bus.c1_op = op; bus.c1_addr = addr; bus.c1_wdata = wd; bus.c1_req = 1'b1;
    end
  endtask

  // Each requester drops req on the cycle it sees its ack; ends one cycle later (IDLE).
  task automatic wait_done(input bit need0, input bit need1);
    bit done0 = !need0;
    bit done1 = !need1;
    int n = 0;
    lat[0] = -1;
    lat[1] = -1;
    while (!(done0 && done1) && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.c0_ack) begin
        if (done0) stray++;
        else begin lat[0] = n; rd[0] = bus.c0_rdata; mis[0] = bus.c0_misalign; end
        done0 = 1'b1;
        bus.c0_req = 1'b0;
      end
      if (bus.c1_ack) begin
        if (done1) stray++;
        else begin lat[1] = n; rd[1] = bus.c1_rdata; mis[1] = bus.c1_misalign; end
        done1 = 1'b1;
        bus.c1_req = 1'b0;
      end
    end
    bus.c0_req = 1'b0;
    bus.c1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_c0_ack"}, {31'b0, bus.c0_ack}, 0);
    check({tag, "_c1_ack"}, {31'b0, bus.c1_ack}, 0);
    check({tag, "_c0_mis"}, {31'b0, bus.c0_misalign}, 0);
    check({tag, "_c1_mis"}, {31'b0, bus.c1_misalign}, 0);
    check({tag, "_mem_en"}, {31'b0, bus.mem_en}, 0);
    check({tag, "_mem_we"}, {31'b0, bus.mem_we}, 0);
    check({tag, "_mem_addr"}, {23'b0, bus.mem_addr}, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_c0_rdata"}, bus.c0_rdata, 0);
    check({tag, "_c1_rdata"}, bus.c1_rdata, 0);
  endtask

  initial begin
    bus.ld_busy = 1'b0;
    bus.c0_req = 1'b0; bus.c0_op = OP_LD; bus.c0_addr = '0; bus.c0_wdata = '0;
    bus.c1_req = 1'b0; bus.c1_op = OP_LD; bus.c1_addr = '0; bus.c1_wdata = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;
    @(negedge clk);

    // Core 0 store then load of byte address 20 (word 5); core 1 stays silent.
    drive(0, OP_ST, 32'd20, 32'h7);
    wait_done(1, 0);
    check("st_lat", lat[0], 2);
    check("st_ram5", ram[5], 32'h7);
    drive(0, OP_LD, 32'd20, 32'h0);
    wait_done(1, 0);
    check("ld_lat", lat[0], 3);
    check("ld_rdata", rd[0], 32'h7);
    check("ld_mis", {31'b0, mis[0]}, 0);
    check("c1_quiet", stray, 0);

    drive(1, OP_ST, 32'd24, 32'h1234_5678);
    wait_done(0, 1);
    check("c1_st_lat", lat[1], 2);
    check("c1_st_ram6", ram[6], 32'h1234_5678);

    // Reset restores last_grant, so a tie goes to core 0; core 1 follows after DONE+IDLE.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(0, OP_LD, 32'd20, 32'h0);
    drive(1, OP_LD, 32'd24, 32'h0);
    wait_done(1, 1);
    check("tie1_c0_lat", lat[0], 3);
    check("tie1_c1_lat", lat[1], 7);
    check("tie1_c0_rd", rd[0], 32'h7);
    check("tie1_c1_rd", rd[1], 32'h1234_5678);

    // After a core 0 grant the next tie goes to core 1.
    drive(0, OP_LD, 32'd20, 32'h0);
    wait_done(1, 0);
    drive(0, OP_LD, 32'd24, 32'h0);
    drive(1, OP_LD, 32'd20, 32'h0);
    wait_done(1, 1);
    check("tie2_c1_lat", lat[1], 3);
    check("tie2_c0_lat", lat[0], 7);
    check("tie2_c0_rd", rd[0], 32'h1234_5678);
    check("tie2_c1_rd", rd[1], 32'h7);

    // A store leaves the core's rdata untouched.
    drive(1, OP_ST, 32'd40, 32'h0);
    wait_done(0, 1);
    check("st_keeps_rdata", bus.c1_rdata, 32'h7);

    // Competing exchanges on word 10: the winner sees 0, the loser sees the winner's 1.
    drive(0, OP_XCHG, 32'd40, 32'h1);
    drive(1, OP_XCHG, 32'd40, 32'h1);
    wait_done(1, 1);
    check("xchg_c0_lat", lat[0], 3);
    check("xchg_c1_lat", lat[1], 7);
    check("xchg_c0_old", rd[0], 32'h0);
    check("xchg_c1_old", rd[1], 32'h1);
    check("xchg_ram10", ram[10], 32'h1);

    // Misaligned load: 0x16 selects word 5, misalign pulses for exactly the ack cycle.
    drive(1, OP_LD, 32'h16, 32'h0);
    wait_done(0, 1);
    check("mis_lat", lat[1], 3);
    check("mis_rd", rd[1], 32'h7);
    check("mis_flag", {31'b0, mis[1]}, 1);
    check("mis_pulse_end", {31'b0, bus.c1_misalign}, 0);

    // Loader owns the RAM: no grant, no strobe, until ld_busy drops.
    bus.ld_busy = 1'b1;
    drive(0, OP_LD, 32'd20, 32'h0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | bus.mem_en | bus.c0_ack;
    end
    check("ldbusy_quiet", {31'b0, seen}, 0);
    bus.ld_busy = 1'b0;
    wait_done(1, 0);
    check("ldbusy_lat", lat[0], 3);
    check("ldbusy_rd", rd[0], 32'h7);

    // Reset in the LAT cycle of an exchange: no write, no ack, everything cleared.
    drive(0, OP_ST, 32'd40, 32'h0);
    wait_done(1, 0);
    check("pre_rst_ram10", ram[10], 32'h0);
    drive(0, OP_XCHG, 32'd40, 32'h1);
    repeat (2) @(negedge clk);
    check("lat_we_pending", {31'b0, bus.mem_we}, 1);
    rst = 1'b0;
    #1;
    check_quiet("mid_reset");
    bus.c0_req = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bus.c0_ack | bus.c1_ack | bus.mem_en;
    end
    check("rst_no_ack", {31'b0, seen}, 0);
    check("rst_ram10", ram[10], 32'h0);
    rst = 1'b1;
    drive(0, OP_LD, 32'd24, 32'h0);
    drive(1, OP_LD, 32'd20, 32'h0);
    wait_done(1, 1);
    check("post_rst_c0_lat", lat[0], 3);
    check("post_rst_c1_lat", lat[1], 7);
    check("post_rst_c0_rd", rd[0], 32'h1234_5678);
    check("stray_acks", stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
